// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter and its requesters.
package uart_tx_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   localparam logic [7:0] EOL_CHAR = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searches last+1, last+2, ...
// wrapping at N_REQ-1 -> 0. Returns whether any request is up and its index.
module rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic             o_any,
   output logic [IDX_W-1:0] o_idx
);

   int w_j;

   // Walk farthest-first so the closest hit after i_last wins.
   always_comb begin
      o_any = 1'b0;
      o_idx = '0;
      w_j   = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_j = (int'(i_last) + k) % N_REQ;
         if (i_req[IDX_W'(w_j)]) begin
            o_any = 1'b1;
            o_idx = IDX_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin share of one buffered UART TX.
// Define UART_ARB_TIMEOUT_EN to release a lock after TIMEOUT idle owner cycles.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter  int N_REQ   = 4,
   parameter  int TIMEOUT = 1024,
   localparam int IDX_W   = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   ack,
   input  logic               tx_ready,
   output logic [7:0]         tx_din,
   output logic               tx_wen,
   output logic               busy,
   output logic [IDX_W-1:0]   owner
);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
      $error("uart_tx_arbiter: N_REQ must be 2..8");
   end
   if (TIMEOUT < 1) begin : g_bad_to
      $error("uart_tx_arbiter: TIMEOUT must be >= 1");
   end

   arb_state_e       r_state;
   arb_state_e       w_state_nx;
   logic [IDX_W-1:0] r_owner;
   logic [IDX_W-1:0] w_owner_nx;
   logic             r_busy;
   logic             w_busy_nx;
   logic             w_any;
   logic [IDX_W-1:0] w_pick;
   logic             w_xfer;
   logic             w_expire;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .i_req  (req),
      .i_last (r_owner),
      .o_any  (w_any),
      .o_idx  (w_pick)
   );

   assign w_xfer = (r_state == ARB_LOCKED) & req[r_owner] & tx_ready;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nx;

   // Backpressure with a pending byte is not idleness; only a silent owner counts.
   always_comb begin
      w_cnt_nx = r_cnt;
      if (r_state == ARB_IDLE || w_xfer) begin
         w_cnt_nx = '0;
      end else if (!req[r_owner]) begin
         w_cnt_nx = r_cnt + 1'b1;
      end
   end

   assign w_expire = (r_state == ARB_LOCKED) && !req[r_owner] &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nx;
      end
   end
`else
   assign w_expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
         r_owner <= IDX_W'(N_REQ - 1);
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_owner <= w_owner_nx;
         r_busy  <= w_busy_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_owner_nx = r_owner;
      w_busy_nx  = r_busy;
      unique case (r_state)
         ARB_IDLE: begin
            if (w_any) begin
               w_state_nx = ARB_LOCKED;
               w_owner_nx = w_pick;
               w_busy_nx  = 1'b1;
            end
         end
         ARB_LOCKED: begin
            if ((w_xfer && req_last[r_owner]) || w_expire) begin
               w_state_nx = ARB_IDLE;
               w_busy_nx  = 1'b0;
            end
         end
         default: begin
            w_state_nx = ARB_IDLE;
            w_busy_nx  = 1'b0;
         end
      endcase
   end

   always_comb begin
      tx_wen = w_xfer;
      ack    = '0;
      tx_din = 8'h00;
      if (w_xfer) begin
         ack    = N_REQ'(1) << r_owner;
         tx_din = req_data[{r_owner, 3'b000} +: 8];
      end
   end

   assign busy  = r_busy;
   assign owner = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive bytes,
// the monitor checks every TX write against hand-ordered expectations.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   ack;
   logic           tx_ready;
   logic [7:0]     tx_din;
   logic           tx_wen;
   logic           busy;
   logic [1:0]     owner;

   logic [8:0]     rq[N][$];
   logic [9:0]     exp_q[$];
   logic [N-1:0]   hold;
   logic [N-1:0]   ack_prev;
   int             n_tests;
   int             n_fail;

   uart_tx_arbiter #(
      .N_REQ   (N),
      .TIMEOUT (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .req_last (req_last),
      .ack      (ack),
      .tx_ready (tx_ready),
      .tx_din   (tx_din),
      .tx_wen   (tx_wen),
      .busy     (busy),
      .owner    (owner)
   );

   always #5 clk = ~clk;

   // Requesters drive at negedge+1, monitor samples at negedge+2.
   always @(negedge clk) begin
      logic [9:0] e;
      logic [3:0] oh;
      #1;
      for (int i = 0; i < N; i++) begin
         if (ack_prev[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() > 0 && !hold[i]) begin
            req[i]            = 1'b1;
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]       = rq[i][0][8];
         end else begin
            req[i]            = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]       = 1'b0;
         end
      end
      #1;
      n_tests++;
      if (tx_wen) begin
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got din=%h ack=%b, required no write",
                     tx_din, ack);
         end else begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e[9:8];
            if (tx_din !== e[7:0] || ack !== oh) begin
               n_fail++;
               $display("FAIL sb_byte: got din=%h ack=%b, required din=%h ack=%b",
                        tx_din, ack, e[7:0], oh);
            end
         end
      end else if (ack !== '0) begin
         n_fail++;
         $display("FAIL sb_ack_no_wen: got ack=%b, required 0", ack);
      end
      ack_prev = ack;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req_v);
      n_tests++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, req_v);
      end
   endtask

   task automatic push(int i, logic [7:0] b, logic last);
      rq[i].push_back({last, b});
   endtask

   task automatic expb(int i, logic [7:0] b);
      logic [1:0] ix;
      ix = i[1:0];
      exp_q.push_back({ix, b});
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(string nm, int maxc);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < maxc) begin
         @(negedge clk);
         c++;
      end
      tick(3);
      #3;
      chk({nm, "_drain"}, exp_q.size(), 0);
      chk({nm, "_busy"}, busy, 0);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      tx_ready = 1'b1;
      hold     = '0;
      ack_prev = '0;
      req      = '0;
      req_data = '0;
      req_last = '0;

      // 1: reset with all four requesting, then rotation from requester 0
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         push(i, 8'h10 + 8'(i), 1'b1);
         expb(i, 8'h10 + 8'(i));
      end
      tick(2);
      #3;
      chk("rst_ack", ack, 0);
      chk("rst_wen", tx_wen, 0);
      chk("rst_din", tx_din, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 3);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      #3;
      chk("t1_busy", busy, 1);
      chk("t1_owner", owner, 0);
      drain("t1", 100);

      // 2: three-byte message at full rate
      @(negedge clk);
      push(1, 8'h41, 1'b0); expb(1, 8'h41);
      push(1, 8'h42, 1'b0); expb(1, 8'h42);
      push(1, 8'h43, 1'b1); expb(1, 8'h43);
      tick(1); #3;
      chk("t2_b0", {tx_wen, tx_din}, 9'h141);
      chk("t2_owner", owner, 1);
      tick(1); #3;
      chk("t2_b1", {tx_wen, tx_din}, 9'h142);
      tick(1); #3;
      chk("t2_b2", {tx_wen, tx_din}, 9'h143);
      tick(1); #3;
      chk("t2_busy_fall", busy, 0);
      chk("t2_idle_wen", tx_wen, 0);
      drain("t2", 50);

      // 3: requesters 0 and 2 alternate after reset
      @(negedge clk);
      rst_n = 1'b0;
      push(0, 8'hA0, 1'b1);
      push(0, 8'hA1, 1'b1);
      push(2, 8'hC0, 1'b1);
      push(2, 8'hC1, 1'b1);
      expb(0, 8'hA0); expb(2, 8'hC0);
      expb(0, 8'hA1); expb(2, 8'hC1);
      tick(1);
      rst_n = 1'b1;
      drain("t3", 100);
      chk("t3_owner", owner, 2);

      // 4: backpressure for 5 cycles mid-message
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
         push(3, 8'h31 + 8'(b), b == 3);
         expb(3, 8'h31 + 8'(b));
      end
      tick(2);
      tx_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #3;
         chk("t4_stall", {ack, tx_wen}, 0);
         @(negedge clk);
      end
      tx_ready = 1'b1;
      drain("t4", 100);

      // 5: owner goes silent mid-message while requester 0 waits
      @(negedge clk);
      push(3, 8'h51, 1'b0);
      push(3, 8'h52, 1'b1);
      expb(3, 8'h51);
      tick(2);
      hold[3] = 1'b1;
      push(0, 8'h01, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
      expb(0, 8'h01);
`endif
      tick(40);
      #3;
`ifdef UART_ARB_TIMEOUT_EN
      chk("t5_busy", busy, 0);
      chk("t5_owner", owner, 0);
`else
      chk("t5_busy", busy, 1);
      chk("t5_owner", owner, 3);
`endif
      chk("t5_pending", exp_q.size(), 0);
      @(negedge clk);
      hold[3] = 1'b0;
      expb(3, 8'h52);
`ifndef UART_ARB_TIMEOUT_EN
      expb(0, 8'h01);
`endif
      drain("t5", 100);

      // 6: reset mid-message, requesters re-send
      @(negedge clk);
      for (int b = 0; b < 4; b++) push(1, 8'h61 + 8'(b), b == 3);
      expb(1, 8'h61);
      expb(1, 8'h62);
      tick(3);
      rst_n = 1'b0;
      #3;
      chk("t6_async", {ack, tx_wen, tx_din, busy}, 0);
      chk("t6_owner", owner, 3);
      @(negedge clk);
      rq[1].delete();
      push(0, 8'h0F, 1'b1);
      expb(0, 8'h0F);
      for (int b = 0; b < 4; b++) begin
         push(1, 8'h61 + 8'(b), b == 3);
         expb(1, 8'h61 + 8'(b));
      end
      @(negedge clk);
      rst_n = 1'b1;
      drain("t6", 100);
      chk("t6_owner_end", owner, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
